id_ex_operand_stage: RTL

- ID/EX pipeline register sitting directly downstream of the register file's combinational read ports.
- Captures rs/rt read data each cycle and resolves RAW hazards by forwarding from EX and MEM.
- Detects load-use hazards and holds ID for one cycle, inserting a bubble into EX.
- Provides a saturating hazard-stall counter for performance debug.

---
 rtl/id_ex_operand_stage.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with EX/MEM operand forwarding, load-use bubble insertion and a saturating stall counter.
// Optional macro WB_BYPASS_EN adds a lowest-priority write-back forward path for posedge-write register files.
module id_ex_operand_stage #(
    parameter int DW   = 32,
    parameter int AW   = 5,
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            id_valid,
    input  logic [AW-1:0]   id_raddr1,
    input  logic [AW-1:0]   id_raddr2,
    input  logic            id_use1,
    input  logic            id_use2,
    input  logic [DW-1:0]   rf_rdata1,
    input  logic [DW-1:0]   rf_rdata2,
    input  logic [AW-1:0]   id_waddr,
    input  logic            id_wen,
    input  logic            id_is_load,
    input  logic [DW-1:0]   ex_result,
    input  logic            mem_wen,
    input  logic [AW-1:0]   mem_waddr,
    input  logic [DW-1:0]   mem_wdata,
    input  logic            flush,
    input  logic            ex_stall,
`ifdef WB_BYPASS_EN
    input  logic            wb_wen,
    input  logic [AW-1:0]   wb_waddr,
    input  logic [DW-1:0]   wb_wdata,
`endif
    output logic            id_stall,
    output logic            ex_valid,
    output logic [DW-1:0]   ex_op_a,
    output logic [DW-1:0]   ex_op_b,
    output logic [AW-1:0]   ex_waddr,
    output logic            ex_wen,
    output logic            ex_is_load,
    output logic [CNTW-1:0] stall_cnt
);
    localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};
    localparam logic [CNTW-1:0] CNT_ONE = {{(CNTW-1){1'b0}}, 1'b1};
    localparam logic [AW-1:0]   REG_ZERO = {AW{1'b0}};

    logic            ex_valid_r;
    logic            ex_wen_r;
    logic            ex_is_load_r;
    logic [DW-1:0]   ex_op_a_r;
    logic [DW-1:0]   ex_op_b_r;
    logic [AW-1:0]   ex_waddr_r;
    logic [CNTW-1:0] stall_cnt_r;

    logic            ex_fwd_en_s;
    logic            luh_s;
    logic [DW-1:0]   op_a_s;
    logic [DW-1:0]   op_b_s;

    // Hazard detection; a load in EX has no data yet, so it can only stall, never forward
    always_comb begin
        ex_fwd_en_s = ex_valid_r & ex_wen_r & ~ex_is_load_r;
        luh_s = id_valid & ex_valid_r & ex_is_load_r & ex_wen_r & (ex_waddr_r != REG_ZERO) &
                ((id_use1 & (id_raddr1 == ex_waddr_r)) | (id_use2 & (id_raddr2 == ex_waddr_r)));
    end

    assign id_stall = luh_s | ex_stall;

    // Operand A source select: r0, EX, MEM, (WB), register file
    always_comb begin
        op_a_s = rf_rdata1;
        if (id_raddr1 == REG_ZERO) begin
            op_a_s = {DW{1'b0}};
        end else if (ex_fwd_en_s && (ex_waddr_r == id_raddr1)) begin
            op_a_s = ex_result;
        end else if (mem_wen && (mem_waddr == id_raddr1)) begin
            op_a_s = mem_wdata;
`ifdef WB_BYPASS_EN
        end else if (wb_wen && (wb_waddr == id_raddr1)) begin
            op_a_s = wb_wdata;
`endif
        end else begin
            op_a_s = rf_rdata1;
        end
    end

    // Operand B source select: r0, EX, MEM, (WB), register file
    always_comb begin
        op_b_s = rf_rdata2;
        if (id_raddr2 == REG_ZERO) begin
            op_b_s = {DW{1'b0}};
        end else if (ex_fwd_en_s && (ex_waddr_r == id_raddr2)) begin
            op_b_s = ex_result;
        end else if (mem_wen && (mem_waddr == id_raddr2)) begin
            op_b_s = mem_wdata;
`ifdef WB_BYPASS_EN
        end else if (wb_wen && (wb_waddr == id_raddr2)) begin
            op_b_s = wb_wdata;
`endif
        end else begin
            op_b_s = rf_rdata2;
        end
    end

    // ID/EX register: hold on EX back-pressure, bubble on flush or load-use, else capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_r   <= 1'b0;
            ex_wen_r     <= 1'b0;
            ex_is_load_r <= 1'b0;
            ex_op_a_r    <= {DW{1'b0}};
            ex_op_b_r    <= {DW{1'b0}};
            ex_waddr_r   <= REG_ZERO;
        end else if (ex_stall) begin
            ex_valid_r   <= ex_valid_r;
            ex_wen_r     <= ex_wen_r;
            ex_is_load_r <= ex_is_load_r;
            ex_op_a_r    <= ex_op_a_r;
            ex_op_b_r    <= ex_op_b_r;
            ex_waddr_r   <= ex_waddr_r;
        end else if (flush || luh_s) begin
            ex_valid_r   <= 1'b0;
            ex_wen_r     <= 1'b0;
            ex_is_load_r <= 1'b0;
            ex_op_a_r    <= {DW{1'b0}};
            ex_op_b_r    <= {DW{1'b0}};
            ex_waddr_r   <= REG_ZERO;
        end else begin
            ex_valid_r   <= id_valid;
            ex_wen_r     <= id_wen & id_valid;
            ex_is_load_r <= id_is_load & id_valid;
            ex_op_a_r    <= op_a_s;
            ex_op_b_r    <= op_b_s;
            ex_waddr_r   <= id_waddr;
        end
    end

    // Saturating count of bubbles caused by load-use hazards
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_r <= {CNTW{1'b0}};
        end else if (luh_s && !ex_stall && (stall_cnt_r != CNT_MAX)) begin
            stall_cnt_r <= stall_cnt_r + CNT_ONE;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign ex_valid   = ex_valid_r;
    assign ex_wen     = ex_wen_r;
    assign ex_is_load = ex_is_load_r;
    assign ex_op_a    = ex_op_a_r;
    assign ex_op_b    = ex_op_b_r;
    assign ex_waddr   = ex_waddr_r;
    assign stall_cnt  = stall_cnt_r;

endmodule
